// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
//
// Latches the decoded control bundle and the ID-stage operands once per cycle.
// A bubble (all zeros) is loaded on load-use stall, branch/jump flush, and
// while the ecall-halt sequencer is draining or halted.
//
// The halt sequencer starts when a valid ecall with halt_cond set sits in EX.
// It then counts down DRAIN_CYCLES-1 edges in DRAIN and ends in HALTED, which
// only reset leaves.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   stall, flush        bubble requests (load-use hazard, redirect from EX)
//   id_*                decoded control bundle, operands and indices from ID
//   ex_*                registered copies presented to EX
//   freeze_upstream     combinational, high in DRAIN/HALTED (hold PC and IF/ID)
//   is_halted           registered, high only in HALTED
module id_ex_pipeline_reg #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic            id_mem_read,
    input  logic            id_mem_to_reg,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_write_enable,
    input  logic            id_pc_to_reg,
    input  logic            id_is_ecall,
    input  logic            id_halt_cond,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_write_enable,
    output logic            ex_pc_to_reg,
    output logic            ex_is_ecall,
    output logic            ex_halt_cond,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            freeze_upstream,
    output logic            is_halted
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_halted_q, is_halted_d;

    logic            ex_valid_q,        ex_valid_d;
    logic            ex_mem_read_q,     ex_mem_read_d;
    logic            ex_mem_to_reg_q,   ex_mem_to_reg_d;
    logic            ex_mem_write_q,    ex_mem_write_d;
    logic            ex_alu_src_q,      ex_alu_src_d;
    logic            ex_write_enable_q, ex_write_enable_d;
    logic            ex_pc_to_reg_q,    ex_pc_to_reg_d;
    logic            ex_is_ecall_q,     ex_is_ecall_d;
    logic            ex_halt_cond_q,    ex_halt_cond_d;
    logic [3:0]      ex_alu_ctrl_q,     ex_alu_ctrl_d;
    logic [XLEN-1:0] ex_pc_q,           ex_pc_d;
    logic [XLEN-1:0] ex_rs1_data_q,     ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q,     ex_rs2_data_d;
    logic [XLEN-1:0] ex_imm_q,          ex_imm_d;
    logic [4:0]      ex_rs1_q,          ex_rs1_d;
    logic [4:0]      ex_rs2_q,          ex_rs2_d;
    logic [4:0]      ex_rd_q,           ex_rd_d;

    logic halt_hit;
    logic load_id;

    assign halt_hit = ex_valid_q & ex_is_ecall_q & ex_halt_cond_q;

    // Every bubble source (freeze, halt squash, flush, stall) produces the same
    // all-zero payload, so the priority list collapses to one load condition.
    assign load_id = (state_q == ST_RUN) & ~halt_hit & ~flush & ~stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_START;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        is_halted_d = (state_d == ST_HALTED);
    end

    always_comb begin
        ex_valid_d        = '0;
        ex_mem_read_d     = '0;
        ex_mem_to_reg_d   = '0;
        ex_mem_write_d    = '0;
        ex_alu_src_d      = '0;
        ex_write_enable_d = '0;
        ex_pc_to_reg_d    = '0;
        ex_is_ecall_d     = '0;
        ex_halt_cond_d    = '0;
        ex_alu_ctrl_d     = '0;
        ex_pc_d           = '0;
        ex_rs1_data_d     = '0;
        ex_rs2_data_d     = '0;
        ex_imm_d          = '0;
        ex_rs1_d          = '0;
        ex_rs2_d          = '0;
        ex_rd_d           = '0;
        if (load_id) begin
            ex_valid_d        = id_valid;
            ex_mem_read_d     = id_mem_read;
            ex_mem_to_reg_d   = id_mem_to_reg;
            ex_mem_write_d    = id_mem_write;
            ex_alu_src_d      = id_alu_src;
            ex_write_enable_d = id_write_enable;
            ex_pc_to_reg_d    = id_pc_to_reg;
            ex_is_ecall_d     = id_is_ecall;
            ex_halt_cond_d    = id_halt_cond;
            ex_alu_ctrl_d     = id_alu_ctrl;
            ex_pc_d           = id_pc;
            ex_rs1_data_d     = id_rs1_data;
            ex_rs2_data_d     = id_rs2_data;
            ex_imm_d          = id_imm;
            ex_rs1_d          = id_rs1;
            ex_rs2_d          = id_rs2;
            ex_rd_d           = id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_RUN;
            cnt_q             <= '0;
            is_halted_q       <= 1'b0;
            ex_valid_q        <= 1'b0;
            ex_mem_read_q     <= 1'b0;
            ex_mem_to_reg_q   <= 1'b0;
            ex_mem_write_q    <= 1'b0;
            ex_alu_src_q      <= 1'b0;
            ex_write_enable_q <= 1'b0;
            ex_pc_to_reg_q    <= 1'b0;
            ex_is_ecall_q     <= 1'b0;
            ex_halt_cond_q    <= 1'b0;
            ex_alu_ctrl_q     <= '0;
            ex_pc_q           <= '0;
            ex_rs1_data_q     <= '0;
            ex_rs2_data_q     <= '0;
            ex_imm_q          <= '0;
            ex_rs1_q          <= '0;
            ex_rs2_q          <= '0;
            ex_rd_q           <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            is_halted_q       <= is_halted_d;
            ex_valid_q        <= ex_valid_d;
            ex_mem_read_q     <= ex_mem_read_d;
            ex_mem_to_reg_q   <= ex_mem_to_reg_d;
            ex_mem_write_q    <= ex_mem_write_d;
            ex_alu_src_q      <= ex_alu_src_d;
            ex_write_enable_q <= ex_write_enable_d;
            ex_pc_to_reg_q    <= ex_pc_to_reg_d;
            ex_is_ecall_q     <= ex_is_ecall_d;
            ex_halt_cond_q    <= ex_halt_cond_d;
            ex_alu_ctrl_q     <= ex_alu_ctrl_d;
            ex_pc_q           <= ex_pc_d;
            ex_rs1_data_q     <= ex_rs1_data_d;
            ex_rs2_data_q     <= ex_rs2_data_d;
            ex_imm_q          <= ex_imm_d;
            ex_rs1_q          <= ex_rs1_d;
            ex_rs2_q          <= ex_rs2_d;
            ex_rd_q           <= ex_rd_d;
        end
    end

    assign ex_valid        = ex_valid_q;
    assign ex_mem_read     = ex_mem_read_q;
    assign ex_mem_to_reg   = ex_mem_to_reg_q;
    assign ex_mem_write    = ex_mem_write_q;
    assign ex_alu_src      = ex_alu_src_q;
    assign ex_write_enable = ex_write_enable_q;
    assign ex_pc_to_reg    = ex_pc_to_reg_q;
    assign ex_is_ecall     = ex_is_ecall_q;
    assign ex_halt_cond    = ex_halt_cond_q;
    assign ex_alu_ctrl     = ex_alu_ctrl_q;
    assign ex_pc           = ex_pc_q;
    assign ex_rs1_data     = ex_rs1_data_q;
    assign ex_rs2_data     = ex_rs2_data_q;
    assign ex_imm          = ex_imm_q;
    assign ex_rs1          = ex_rs1_q;
    assign ex_rs2          = ex_rs2_q;
    assign ex_rd           = ex_rd_q;

    assign freeze_upstream = (state_q != ST_RUN);
    assign is_halted       = is_halted_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios followed by
// randomized traffic, all checked against a bundle-level reference model.
module tb_id_ex_pipeline_reg;

    localparam int XLEN = 32;
    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic            valid;
        logic            mem_read;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            write_enable;
        logic            pc_to_reg;
        logic            is_ecall;
        logic            halt_cond;
        logic [3:0]      alu_ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } bundle_t;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    logic    stall = 1'b0;
    logic    flush = 1'b0;
    bundle_t id_in = '0;
    bundle_t ex_out;

    logic            ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
    logic            ex_write_enable, ex_pc_to_reg, ex_is_ecall, ex_halt_cond;
    logic [3:0]      ex_alu_ctrl;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            freeze_upstream, is_halted;

    int total = 0;
    int bad = 0;

    // Reference model: the expected EX bundle, plus the number of edges since
    // the halting ecall was seen in EX (-1 when no halt is in progress).
    bundle_t m_ex;
    int      m_since;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(
        .XLEN(XLEN),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_in.valid), .id_mem_read(id_in.mem_read),
        .id_mem_to_reg(id_in.mem_to_reg), .id_mem_write(id_in.mem_write),
        .id_alu_src(id_in.alu_src), .id_write_enable(id_in.write_enable),
        .id_pc_to_reg(id_in.pc_to_reg), .id_is_ecall(id_in.is_ecall),
        .id_halt_cond(id_in.halt_cond), .id_alu_ctrl(id_in.alu_ctrl),
        .id_pc(id_in.pc), .id_rs1_data(id_in.rs1_data),
        .id_rs2_data(id_in.rs2_data), .id_imm(id_in.imm),
        .id_rs1(id_in.rs1), .id_rs2(id_in.rs2), .id_rd(id_in.rd),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_write_enable(ex_write_enable),
        .ex_pc_to_reg(ex_pc_to_reg), .ex_is_ecall(ex_is_ecall),
        .ex_halt_cond(ex_halt_cond), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .freeze_upstream(freeze_upstream), .is_halted(is_halted)
    );

    assign ex_out = {ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                     ex_write_enable, ex_pc_to_reg, ex_is_ecall, ex_halt_cond,
                     ex_alu_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                     ex_rs1, ex_rs2, ex_rd};

    task automatic check(input string tag, input logic [$bits(bundle_t)-1:0] got,
                         input logic [$bits(bundle_t)-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ex"}, ex_out, m_ex);
        check({tag, "_halted"}, is_halted, m_since >= DRAIN_CYCLES);
        check({tag, "_freeze"}, freeze_upstream, m_since >= 1);
    endtask

    // Advance one edge: compute the model's next state from the inputs that
    // are about to be sampled, then check the DUT just after the edge.
    task automatic tick(input string tag);
        logic hit;
        hit = (m_since < 0) && m_ex.valid && m_ex.is_ecall && m_ex.halt_cond;
        if (m_since >= 0 || hit || flush || stall) m_ex = '0;
        else                                       m_ex = id_in;
        if (m_since >= 0) m_since++;
        else if (hit)     m_since = 1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_ex = '0;
        m_since = -1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        reset = 1'b0;
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b.halt_cond = ($urandom_range(0, 3) == 0);
        b.is_ecall  = ($urandom_range(0, 7) == 0);
        return b;
    endfunction

    function automatic bundle_t mk_add();
        bundle_t b;
        b = '0;
        b.valid = 1'b1;
        b.write_enable = 1'b1;
        b.rd = 5'd5;
        b.rs1_data = 32'h11;
        return b;
    endfunction

    initial begin
        bundle_t b;
        m_ex = '0;
        m_since = -1;

        // Reset, then a simple add.
        #2;
        do_reset();
        id_in = mk_add();
        tick("add");
        check("add_rd", ex_rd, 5'd5);
        check("add_rs1", ex_rs1_data, 32'h11);
        // Asynchronous reset in the middle of the cycle.
        #2;
        reset = 1'b1;
        #1;
        m_ex = '0;
        m_since = -1;
        check_all("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Load-use stall with a lw in ID.
        b = '0;
        b.valid = 1'b1; b.mem_read = 1'b1; b.mem_to_reg = 1'b1;
        b.write_enable = 1'b1; b.alu_src = 1'b1; b.rd = 5'd7; b.imm = 32'h40;
        id_in = b;
        stall = 1'b1;
        tick("lw_stall");
        check("lw_stall_valid", ex_valid, 1'b0);
        stall = 1'b0;
        tick("lw_go");
        check("lw_mem_read", ex_mem_read, 1'b1);
        check("lw_mem_to_reg", ex_mem_to_reg, 1'b1);

        // Flush with a sw in ID, then flush and stall together.
        b = '0;
        b.valid = 1'b1; b.mem_write = 1'b1; b.alu_src = 1'b1; b.rs2_data = 32'hdead;
        id_in = b;
        flush = 1'b1;
        tick("sw_flush");
        check("sw_flush_mw", ex_mem_write, 1'b0);
        stall = 1'b1;
        tick("sw_flush_stall");
        check("sw_fs_valid", ex_valid, 1'b0);
        flush = 1'b0;
        stall = 1'b0;
        tick("sw_go");
        check("sw_mem_write", ex_mem_write, 1'b1);

        // Halting ecall: E0 latch, E1 enters drain, halt after E3.
        b = '0;
        b.valid = 1'b1; b.is_ecall = 1'b1; b.halt_cond = 1'b1;
        id_in = b;
        tick("ecall_e0");
        check("e0_ecall", ex_is_ecall, 1'b1);
        id_in = mk_add();
        tick("ecall_e1");
        check("e1_freeze", freeze_upstream, 1'b1);
        tick("ecall_e2");
        check("e2_halted", is_halted, 1'b0);
        tick("ecall_e3");
        check("e3_halted", is_halted, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            flush = i[1];
            tick("halted_hold");
            check("halted_no_load", ex_valid, 1'b0);
        end
        stall = 1'b0;
        flush = 1'b0;

        // Non-halting ecall passes straight through.
        do_reset();
        b = '0;
        b.valid = 1'b1; b.is_ecall = 1'b1; b.pc = 32'h100;
        id_in = b;
        tick("ecall_nohalt");
        check("nohalt_ecall", ex_is_ecall, 1'b1);
        id_in = mk_add();
        tick("after_nohalt");
        check("after_nohalt_freeze", freeze_upstream, 1'b0);
        check("after_nohalt_we", ex_write_enable, 1'b1);

        // Reset during drain aborts the halt.
        b = '0;
        b.valid = 1'b1; b.is_ecall = 1'b1; b.halt_cond = 1'b1;
        id_in = b;
        tick("drain_e0");
        id_in = mk_add();
        tick("drain_e1");
        tick("drain_e2");
        #2;
        reset = 1'b1;
        #1;
        m_ex = '0;
        m_since = -1;
        check_all("drain_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick("drain_after");
        check("drain_after_valid", ex_valid, 1'b1);
        tick("drain_after2");
        check("drain_after2_halted", is_halted, 1'b0);

        // Randomized traffic; a reset is applied some edges after each halt.
        for (int i = 0; i < 600; i++) begin
            id_in = rand_bundle();
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 6) == 0);
            tick("rand");
            if (m_since >= DRAIN_CYCLES + 4) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
